// File: rtl/mem_if_pkg.sv
// Shared constants and state encoding for the cache memory-side interface.
// Contents:
//   LINE_BYTES / OFFSET_W - cache line geometry (4 bytes, 2-bit offset)
//   ADDR_W / DATA_W       - memory bus address and data widths
//   mem_state_e           - responder FSM states
package mem_if_pkg;

    localparam int unsigned LINE_BYTES = 4;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_CAP,
        WR_WAIT
    } mem_state_e;

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port byte RAM used as the responder's backing store.
// The power-up content reads as mem[i] = i[7:0].
// Ports:
//   clock  - write clock, rising edge
//   we     - write enable, data captured on the rising edge
//   addr   - byte address (shared by read and write)
//   wdata  - write data
//   rdata  - asynchronous read data
module mem_byte_ram
    import mem_if_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    // Cells hold content XOR the low address byte, so a zeroed array
    // (the RAM power-up state) reads back as the i[7:0] pattern.
    logic [DATA_W-1:0] cells [DEPTH];
    logic [DATA_W-1:0] addr_pat;

    assign addr_pat = DATA_W'(addr);

    always_ff @(posedge clock) begin
        if (we) begin
            cells[addr] <= wdata ^ addr_pat;
        end
    end

    assign rdata = cells[addr] ^ addr_pat;

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder for the 2-way set associative cache memory port.
// Serves 4-byte critical-byte-first line fills after RD_LATENCY idle cycles
// and absorbs 4-byte line write-backs followed by WR_LATENCY busy cycles.
// Ports:
//   clock     - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   addr_mem  - byte address, [1:0] is the starting offset in the line
//   rd_mem    - line read request level (rising edge accepted in IDLE)
//   wr_mem    - line write request level (rising edge accepted in IDLE)
//   data_mem  - bidirectional data, driven here only during RD_BURST
//   ready_mem - 1 when idle or read data valid, 0 when busy
//   prot_err  - sticky: rd_mem and wr_mem rose on the same cycle
module main_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned WR_LATENCY = 2,
    parameter int unsigned MEM_AW     = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic              rd_mem,
    input  logic              wr_mem,
    inout  wire  [DATA_W-1:0] data_mem,
    output logic              ready_mem,
    output logic              prot_err
);

    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned LAT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int unsigned BASE_W  = MEM_AW - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_BYTES - 1);

    mem_state_e          state;
    logic [BASE_W-1:0]   base;
    logic [OFFSET_W-1:0] off;
    logic [OFFSET_W-1:0] beat;
    logic [LAT_W-1:0]    lat_cnt;
    logic                rd_q;
    logic                wr_q;

    logic                rd_rise;
    logic                wr_rise;
    logic [OFFSET_W-1:0] cur_off;
    logic [MEM_AW-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_rdata;
    logic                ram_we;

    assign rd_rise  = rd_mem & ~rd_q;
    assign wr_rise  = wr_mem & ~wr_q;
    // 2-bit add wraps inside the line: critical byte first.
    assign cur_off  = off + beat;
    assign ram_addr = {base, cur_off};
    assign ram_we   = (state == WR_CAP);

    // Address bits above the storage width alias onto the same bytes.
    if (MEM_AW < ADDR_W) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_mem[ADDR_W-1:MEM_AW];
    end

    mem_byte_ram #(
        .AW (MEM_AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_mem),
        .rdata (ram_rdata)
    );

    // Enable decoded from the state register so reset releases the bus at once.
    assign data_mem = (state == RD_BURST) ? ram_rdata : {DATA_W{1'bz}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base      <= '0;
            off       <= '0;
            beat      <= '0;
            lat_cnt   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ready_mem <= 1'b0;
            prot_err  <= 1'b0;
        end else begin
            rd_q <= rd_mem;
            wr_q <= wr_mem;
            if (rd_rise && wr_rise) begin
                prot_err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    ready_mem <= 1'b1;
                    if (wr_rise) begin
                        // Write wins over a simultaneous read.
                        base      <= addr_mem[MEM_AW-1:OFFSET_W];
                        off       <= addr_mem[OFFSET_W-1:0];
                        beat      <= '0;
                        state     <= WR_CAP;
                        ready_mem <= 1'b0;
                    end else if (rd_rise) begin
                        base <= addr_mem[MEM_AW-1:OFFSET_W];
                        off  <= addr_mem[OFFSET_W-1:0];
                        beat <= '0;
                        if (RD_LATENCY > 0) begin
                            state     <= RD_WAIT;
                            lat_cnt   <= LAT_W'(RD_LATENCY - 1);
                            ready_mem <= 1'b0;
                        end else begin
                            state <= RD_BURST;
                        end
                    end
                end

                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        state     <= RD_BURST;
                        ready_mem <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                RD_BURST: begin
                    // ready_mem stays high straight through into IDLE.
                    beat <= beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state <= IDLE;
                    end
                end

                WR_CAP: begin
                    beat <= beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        if (WR_LATENCY > 0) begin
                            state   <= WR_WAIT;
                            lat_cnt <= LAT_W'(WR_LATENCY - 1);
                        end else begin
                            state     <= IDLE;
                            ready_mem <= 1'b1;
                        end
                    end
                end

                WR_WAIT: begin
                    if (lat_cnt == '0) begin
                        state     <= IDLE;
                        ready_mem <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    ready_mem <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder (default parameters:
// RD_LATENCY=3, WR_LATENCY=2, MEM_AW=10). Table of line transactions plus
// hand-written sequences for held requests, protocol error and mid-burst reset.
module tb_main_mem_responder;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;   // beat 0 in [7:0]: bytes driven (write) or expected (read)
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] addr_mem;
    logic        rd_mem;
    logic        wr_mem;
    wire  [7:0]  data_mem;
    logic        ready_mem;
    logic        prot_err;
    logic [7:0]  tb_drv;
    logic        tb_oe;

    int n_vec = 0;
    int n_err = 0;

    assign data_mem = tb_oe ? tb_drv : 8'bz;

    // Undriven bus floats high so a released bus reads as ff or z.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data_mem[i]);
    end

    main_mem_responder u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .addr_mem  (addr_mem),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .data_mem  (data_mem),
        .ready_mem (ready_mem),
        .prot_err  (prot_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic check_released(input string name);
        n_vec++;
        if (!(data_mem === 8'hzz || data_mem === 8'hff)) begin
            n_err++;
            $display("FAIL %s: data_mem got %h, want released bus", name, data_mem);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Read line; returns with rd_mem still high one cycle after the last beat.
    task automatic do_read(input string tag, input logic [15:0] addr, input logic [31:0] exp,
                           input bit drop);
        @(negedge clock);
        addr_mem = addr;
        rd_mem   = 1'b1;
        tick();
        for (int c = 0; c < RD_LAT; c++) begin
            check($sformatf("%s wait%0d ready", tag, c), {7'b0, ready_mem}, 8'h00);
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            check($sformatf("%s beat%0d ready", tag, b), {7'b0, ready_mem}, 8'h01);
            check($sformatf("%s beat%0d data", tag, b), data_mem, exp[8*b +: 8]);
            tick();
        end
        check($sformatf("%s post ready", tag), {7'b0, ready_mem}, 8'h01);
        check_released($sformatf("%s post bus", tag));
        if (drop) begin
            @(negedge clock);
            rd_mem = 1'b0;
        end
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input logic [31:0] data,
                            input bit with_rd);
        @(negedge clock);
        addr_mem = addr;
        wr_mem   = 1'b1;
        rd_mem   = with_rd;
        tick();
        for (int b = 0; b < 4; b++) begin
            tb_drv = data[8*b +: 8];
            tb_oe  = 1'b1;
            check($sformatf("%s cap%0d ready", tag, b), {7'b0, ready_mem}, 8'h00);
            tick();
        end
        tb_oe = 1'b0;
        for (int c = 0; c < WR_LAT; c++) begin
            check($sformatf("%s busy%0d ready", tag, c), {7'b0, ready_mem}, 8'h00);
            tick();
        end
        check($sformatf("%s done ready", tag), {7'b0, ready_mem}, 8'h01);
        @(negedge clock);
        wr_mem = 1'b0;
        rd_mem = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{wr: 1'b0, addr: 16'h0090, data: 32'h93929190};
        vecs[1] = '{wr: 1'b0, addr: 16'h0093, data: 32'h92919093};
        vecs[2] = '{wr: 1'b1, addr: 16'h006C, data: 32'h44332211};
        vecs[3] = '{wr: 1'b0, addr: 16'h006C, data: 32'h44332211};
        vecs[4] = '{wr: 1'b0, addr: 16'h0492, data: 32'h91909392};
        vecs[5] = '{wr: 1'b0, addr: 16'h02C1, data: 32'hC0C3C2C1};
        vecs[6] = '{wr: 1'b1, addr: 16'h0101, data: 32'hDDCCBBAA};
        vecs[7] = '{wr: 1'b0, addr: 16'h0100, data: 32'hCCBBAADD};
        vecs[8] = '{wr: 1'b0, addr: 16'h0500, data: 32'hCCBBAADD};
        vecs[9] = '{wr: 1'b0, addr: 16'h0103, data: 32'hBBAADDCC};

        reset_n  = 1'b0;
        rd_mem   = 1'b0;
        wr_mem   = 1'b0;
        addr_mem = 16'h0000;
        tb_drv   = 8'h00;
        tb_oe    = 1'b0;

        // Reset state and first-edge ready.
        #1;
        check("reset ready", {7'b0, ready_mem}, 8'h00);
        check("reset prot_err", {7'b0, prot_err}, 8'h00);
        check_released("reset bus");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("first edge ready", {7'b0, ready_mem}, 8'h01);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                do_write($sformatf("v%0d wr", i), vecs[i].addr, vecs[i].data, 1'b0);
            end else begin
                do_read($sformatf("v%0d rd", i), vecs[i].addr, vecs[i].data, 1'b1);
            end
        end

        // rd_mem held high for 20 cycles: exactly one burst.
        do_read("hold", 16'h0090, 32'h93929190, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check($sformatf("hold idle%0d ready", c), {7'b0, ready_mem}, 8'h01);
            check_released($sformatf("hold idle%0d bus", c));
        end
        @(negedge clock);
        rd_mem = 1'b0;

        // Simultaneous rise: write taken, sticky protocol error.
        check("pre prot_err", {7'b0, prot_err}, 8'h00);
        do_write("both", 16'h0000, 32'h04030201, 1'b1);
        check("both prot_err", {7'b0, prot_err}, 8'h01);
        do_read("both rd", 16'h0000, 32'h04030201, 1'b1);
        check("prot_err sticky", {7'b0, prot_err}, 8'h01);

        // Reset during beat 2 of a read.
        @(negedge clock);
        addr_mem = 16'h0040;
        rd_mem   = 1'b1;
        tick();
        for (int c = 0; c < RD_LAT + 2; c++) tick();
        check("rst beat2 data", data_mem, 8'h42);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst async ready", {7'b0, ready_mem}, 8'h00);
        check("rst prot_err clear", {7'b0, prot_err}, 8'h00);
        check_released("rst async bus");
        rd_mem = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("rst release ready", {7'b0, ready_mem}, 8'h01);
        do_read("after rst", 16'h0041, 32'h40434241, 1'b1);

        // Reset during write capture keeps the beats already written.
        @(negedge clock);
        addr_mem = 16'h0080;
        wr_mem   = 1'b1;
        tick();
        tb_oe  = 1'b1;
        tb_drv = 8'h5A;
        tick();
        tb_drv = 8'h6B;
        tick();
        tb_drv = 8'h7C;
        #2;
        reset_n = 1'b0;
        tb_oe   = 1'b0;
        wr_mem  = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("partial wr ready", {7'b0, ready_mem}, 8'h01);
        do_read("partial rd", 16'h0080, 32'h83826B5A, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
